// File: rtl/video_page_engine.sv
// rtl/video_page_engine.sv - video-page select, fill and scrolled copy engine
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   cmd_valid/cmd_ready     page command handshake (accept on valid && ready)
//   cmd_op                  0 select, 1 fill, 2 copy, 3 reserved
//   cmd_page/cmd_src        target/destination page, copy source page
//   cmd_color, cmd_vscroll  fill colour index, signed copy row offset
//   mem_addr/we/re/wdata    single-port framebuffer master, {page, offset}
//   mem_rdata               read data, valid the cycle after mem_re
//   draw_page               page selected for the polygon rasteriser
//   busy, done              operation in progress, one-cycle completion pulse
module video_page_engine #(
    parameter int ROW_WORDS = 80,
    parameter int ROWS      = 200,
    parameter int PAGE_AW   = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [1:0]         cmd_page,
    input  logic [1:0]         cmd_src,
    input  logic [3:0]         cmd_color,
    input  logic [8:0]         cmd_vscroll,
    output logic [PAGE_AW+1:0] mem_addr,
    output logic               mem_we,
    output logic               mem_re,
    output logic [15:0]        mem_wdata,
    input  logic [15:0]        mem_rdata,
    output logic [1:0]         draw_page,
    output logic               busy,
    output logic               done
);

    localparam int RW = $clog2(ROWS);
    localparam int WW = $clog2(ROW_WORDS);
    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(ROW_WORDS - 1);
    localparam logic [8:0]    ROWS9     = 9'(ROWS);

    // S_START is the decode cycle between accept and the first working state.
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FILL, S_COPY_RD, S_COPY_WR, S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_op;
    logic [1:0]    r_page;
    logic [1:0]    r_src;
    logic [3:0]    r_color;
    logic [8:0]    r_vs;
    logic [RW-1:0] r_row;
    logic [RW-1:0] r_last_row;
    logic [WW-1:0] r_word;
    logic          r_up;
    logic [1:0]    r_draw_page;

    logic [8:0]         w_abs;
    logic               w_vs_pos;
    logic               w_copy_none;
    logic [RW-1:0]      w_first_row;
    logic [RW-1:0]      w_last_row;
    logic [RW-1:0]      w_src_row;
    logic [RW-1:0]      w_row_sel;
    logic [PAGE_AW-1:0] w_off;
    logic               w_word_end;
    logic               w_row_last;

    assign w_abs    = r_vs[8] ? (~r_vs + 9'd1) : r_vs;
    assign w_vs_pos = !r_vs[8] && (r_vs != 9'd0);

    // Only destination rows whose source row lies on the page are visited, so
    // the visited set is one contiguous range: [vs, ROWS-1] walked downward for
    // a positive scroll (keeps same-page scrolls from reading overwritten
    // rows), [0, ROWS-1-|vs|] walked upward otherwise.
    assign w_copy_none = ((r_src == r_page) && (r_vs == 9'd0)) || (w_abs >= ROWS9);
    assign w_first_row = w_vs_pos ? LAST_ROW : '0;
    assign w_last_row  = w_vs_pos ? RW'(w_abs) : LAST_ROW - RW'(w_abs);
    assign w_src_row   = r_up ? r_row + RW'(w_abs) : r_row - RW'(w_abs);

    assign w_row_sel  = (r_state == S_COPY_RD) ? w_src_row : r_row;
    assign w_off      = PAGE_AW'(w_row_sel) * PAGE_AW'(ROW_WORDS) + PAGE_AW'(r_word);
    assign w_word_end = (r_word == LAST_WORD);
    assign w_row_last = (r_row == r_last_row);

    assign cmd_ready = (r_state == S_IDLE) && !reset;
    assign draw_page = r_draw_page;

    always_comb begin
        w_next    = r_state;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) w_next = S_START;
            end
            S_START: begin
                case (r_op)
                    2'd1:    w_next = S_FILL;
                    2'd2:    w_next = w_copy_none ? S_DONE : S_COPY_RD;
                    default: w_next = S_DONE;
                endcase
            end
            S_FILL: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_page, w_off};
                mem_wdata = {4{r_color}};
                if (w_word_end && w_row_last) w_next = S_DONE;
            end
            S_COPY_RD: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = {r_src, w_off};
                w_next   = S_COPY_WR;
            end
            S_COPY_WR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_page, w_off};
                mem_wdata = mem_rdata;
                w_next    = (w_word_end && w_row_last) ? S_DONE : S_COPY_RD;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_page      <= '0;
            r_src       <= '0;
            r_color     <= '0;
            r_vs        <= '0;
            r_row       <= '0;
            r_last_row  <= '0;
            r_word      <= '0;
            r_up        <= 1'b1;
            r_draw_page <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_page  <= cmd_page;
                        r_src   <= cmd_src;
                        r_color <= cmd_color;
                        r_vs    <= cmd_vscroll;
                    end
                end
                S_START: begin
                    r_word <= '0;
                    if (r_op == 2'd0) r_draw_page <= r_page;
                    if (r_op == 2'd2) begin
                        r_row      <= w_first_row;
                        r_last_row <= w_last_row;
                        r_up       <= !w_vs_pos;
                    end else begin
                        r_row      <= '0;
                        r_last_row <= LAST_ROW;
                        r_up       <= 1'b1;
                    end
                end
                S_FILL, S_COPY_WR: begin
                    if (w_word_end) begin
                        r_word <= '0;
                        if (!w_row_last) r_row <= r_up ? r_row + RW'(1) : r_row - RW'(1);
                    end else begin
                        r_word <= r_word + WW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_video_page_engine.sv
// tb/tb_video_page_engine.sv - scoreboard bench for video_page_engine
module tb_video_page_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_page;
    logic [1:0]  cmd_src;
    logic [3:0]  cmd_color;
    logic [8:0]  cmd_vscroll;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [1:0]  draw_page;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    video_page_engine dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_page(cmd_page), .cmd_src(cmd_src),
        .cmd_color(cmd_color), .cmd_vscroll(cmd_vscroll),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .draw_page(draw_page), .busy(busy), .done(done)
    );

    localparam int NWORDS = 16000;

    logic [15:0] fb      [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] rdata_q;
    int          cyc = 0;

    assign mem_rdata = rdata_q;

    always @(posedge clk) begin
        if (mem_re) rdata_q <= fb[mem_addr];
        if (mem_we) fb[mem_addr] = mem_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 read, 1 write, 2 done
        logic [15:0] addr;
        logic [15:0] data;
        int          off;    // cycle offset from the accept edge
    } ev_t;

    ev_t        q[$];
    int         base_cyc = 0;
    logic [1:0] exp_draw = 2'd0;
    int         fill_limit = NWORDS;
    int         n_tests = 0;
    int         n_fail = 0;

    function automatic void chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endfunction

    function automatic void push(int kind, int addr, int data, int off);
        ev_t e;
        e.kind = kind;
        e.addr = 16'(addr);
        e.data = 16'(data);
        e.off  = off;
        q.push_back(e);
    endfunction

    function automatic void gen_fill(int page, int color, int limit);
        for (int k = 0; k < limit; k++) begin
            int a = page * 16384 + k;
            int d = color * 'h1111;
            push(1, a, d, k + 1);
            ref_mem[a] = 16'(d);
        end
        if (limit == NWORDS) push(2, 0, 0, NWORDS + 1);
    endfunction

    // dst row y takes src row y - vs; rows with an off-page source are skipped
    function automatic void gen_copy(int src, int dst, int vs);
        int n = 0;
        if (!(src == dst && vs == 0)) begin
            for (int i = 0; i < 200; i++) begin
                int y  = (vs > 0) ? 199 - i : i;
                int sy = y - vs;
                if (sy >= 0 && sy < 200) begin
                    for (int w = 0; w < 80; w++) begin
                        int sa = src * 16384 + sy * 80 + w;
                        int da = dst * 16384 + y * 80 + w;
                        logic [15:0] d = ref_mem[sa];
                        push(0, sa, 0, n + 1);
                        n++;
                        push(1, da, int'(d), n + 1);
                        n++;
                        ref_mem[da] = d;
                    end
                end
            end
        end
        push(2, 0, 0, n + 1);
    endfunction

    int   m_kind;
    ev_t  m_e;
    logic m_ok;

    always @(negedge clk) begin
        if (mem_we && mem_re) begin
            n_tests++;
            n_fail++;
            $display("FAIL strobe_overlap: we=1 re=1 at cycle %0d, required never both", cyc);
        end
        if (mem_we || mem_re || done) begin
            m_kind = done ? 2 : (mem_we ? 1 : 0);
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: kind %0d addr %h at cycle %0d, required no activity",
                         m_kind, mem_addr, cyc);
            end else begin
                m_e  = q.pop_front();
                m_ok = (m_kind == m_e.kind) && (cyc - base_cyc == m_e.off);
                if (m_e.kind != 2) m_ok = m_ok && (mem_addr === m_e.addr) && (busy === 1'b1) && (done === 1'b0);
                if (m_e.kind == 1) m_ok = m_ok && (mem_wdata === m_e.data);
                if (m_e.kind == 2) m_ok = m_ok && (draw_page === exp_draw) && (busy === 1'b0);
                if (m_ok !== 1'b1) begin
                    n_fail++;
                    $display("FAIL event: got kind=%0d addr=%h data=%h off=%0d busy=%b dp=%0d, required kind=%0d addr=%h data=%h off=%0d dp=%0d",
                             m_kind, mem_addr, mem_wdata, cyc - base_cyc, busy, draw_page,
                             m_e.kind, m_e.addr, m_e.data, m_e.off, exp_draw);
                end
            end
        end
    end

    task automatic send(int op, int page, int src, int color, int vs);
        cmd_op      = 2'(op);
        cmd_page    = 2'(page);
        cmd_src     = 2'(src);
        cmd_color   = 4'(color);
        cmd_vscroll = 9'(vs);
        cmd_valid   = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) begin
            @(posedge clk);
            #1;
        end
        chk("accept_ready", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        base_cyc    = cyc;
        cmd_valid   = 1'b0;
        cmd_op      = 2'($urandom);
        cmd_page    = 2'($urandom);
        cmd_src     = 2'($urandom);
        cmd_color   = 4'($urandom);
        cmd_vscroll = 9'($urandom);
        case (op)
            0: begin exp_draw = 2'(page); push(2, 0, 0, 1); end
            1: gen_fill(page, color, fill_limit);
            2: gen_copy(src, page, vs);
            default: push(2, 0, 0, 1);
        endcase
    endtask

    task automatic wait_idle(string nm, int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            chk({nm, "_timeout"}, q.size(), 0);
            q.delete();
        end
        #1;
        chk({nm, "_ready_after_done"}, int'(cmd_ready), 1);
        chk({nm, "_busy_after_done"}, int'(busy), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        for (int i = 0; i < 65536; i++) begin
            fb[i]      = 16'($urandom);
            ref_mem[i] = fb[i];
        end
        rdata_q     = '0;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_page    = '0;
        cmd_src     = '0;
        cmd_color   = '0;
        cmd_vscroll = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_we", int'(mem_we), 0);
        chk("rst_re", int'(mem_re), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);
        chk("rst_busy_done", int'({busy, done}), 0);
        chk("rst_draw_page", int'(draw_page), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", int'(cmd_ready), 1);

        send(0, 2, 0, 0, 0);
        wait_idle("select2", 10);
        chk("select2_draw_page", int'(draw_page), 2);

        send(1, 1, 0, 5, 0);
        wait_idle("fill1", 17000);

        for (int k = 0; k < NWORDS; k++) begin
            fb[k]      = 16'(k);
            ref_mem[k] = 16'(k);
        end
        send(2, 3, 0, 0, 0);
        wait_idle("copy03", 33000);
        mism = 0;
        for (int k = 0; k < NWORDS; k++) if (fb['hC000 + k] !== 16'(k)) mism++;
        chk("copy03_image_mismatches", mism, 0);

        for (int k = 0; k < NWORDS; k++) begin
            fb[k]      = 16'(k / 80);
            ref_mem[k] = 16'(k / 80);
        end
        send(2, 0, 0, 0, 10);
        wait_idle("scroll10", 31000);
        mism = 0;
        for (int y = 0; y < 200; y++)
            for (int w = 0; w < 80; w++)
                if (fb[y * 80 + w] !== 16'((y < 10) ? y : y - 10)) mism++;
        chk("scroll10_image_mismatches", mism, 0);

        send(2, 2, 3, 0, -199);
        wait_idle("vs_m199", 400);
        send(2, 1, 0, 0, 200);
        wait_idle("vs_200", 10);

        for (int t = 0; t < 8; t++) begin
            int op  = $urandom_range(0, 3);
            int pg  = $urandom_range(0, 3);
            int src = $urandom_range(0, 3);
            int vs;
            if (op == 1) op = 2;
            case ($urandom_range(0, 3))
                0:       begin vs = 0; src = pg; end
                default: begin
                    vs = $urandom_range(196, 215);
                    if ($urandom_range(0, 1) == 1) vs = -vs;
                end
            endcase
            send(op, pg, src, $urandom_range(0, 15), vs);
            wait_idle("random", 2000);
        end

        send(0, 3, 0, 0, 0);
        wait_idle("select3", 10);
        fill_limit = 499;
        send(1, 2, 0, 9, 0);
        repeat (499) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_we", int'(mem_we), 0);
        chk("abort_re", int'(mem_re), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ready_in_reset", int'(cmd_ready), 0);
        chk("abort_draw_page", int'(draw_page), 0);
        chk("abort_events_left", q.size(), 0);
        exp_draw   = 2'd0;
        fill_limit = NWORDS;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_idle_ready", int'(cmd_ready), 1);
        send(0, 1, 0, 0, 0);
        wait_idle("select_after_abort", 10);
        chk("select1_draw_page", int'(draw_page), 1);

        repeat (3) @(posedge clk);
        mism = 0;
        for (int i = 0; i < 65536; i++) if (fb[i] !== ref_mem[i]) mism++;
        chk("final_image_mismatches", mism, 0);
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_page_engine.md
# video_page_engine

Executes the CPU's video-page opcodes: selectVideoPage, fillVideoPage and copyVideoPage. It sits directly downstream of the bytecode CPU. It accepts one decoded page command at a time over a valid/ready handshake and performs the page-wide fill or vertically scrolled page copy against a single-port framebuffer RAM. It also holds the currently selected drawing page for the polygon rasteriser.

## Interface
Parameters:
- `ROW_WORDS`, default 80: 16-bit words per row. Each word holds 4 pixels of 4 bpp, so a 320-pixel row is 80 words.
- `ROWS`, default 200: rows per page.
- `PAGE_AW`, default 14: word-offset width inside a page. Page base address = `{page, 14'b0}`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle and able to accept a command.
- `cmd_op` in 2: 0 = select, 1 = fill, 2 = copy, 3 = reserved (no-op).
- `cmd_page` in 2: target page for select and fill; destination page for copy.
- `cmd_src` in 2: source page for copy.
- `cmd_color` in 4: fill colour index.
- `cmd_vscroll` in 9: signed row offset for copy, valid range -199..199.
- `mem_addr` out 16: framebuffer word address.
- `mem_we` out 1: write strobe.
- `mem_re` out 1: read strobe.
- `mem_wdata` out 16: write data.
- `mem_rdata` in 16: read data, valid exactly one cycle after `mem_re`.
- `draw_page` out 2: currently selected drawing page.
- `busy` out 1: a fill or copy is in progress.
- `done` out 1: one-cycle pulse when a command completes.

## Operation
- States: IDLE, FILL, COPY_RD, COPY_WR, DONE.
- Reset values: IDLE, `cmd_ready`=0 during reset and 1 after it, `draw_page`=0, `busy`=0, `done`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0.
- A command is accepted on the cycle where `cmd_valid && cmd_ready`. All command fields are latched on that cycle.
- `cmd_ready` = (state==IDLE) && !reset.

Select (op 0):
- `draw_page` takes `cmd_page` on the next edge.
- The engine goes to DONE. It makes no memory access.

Fill (op 1):
- `mem_wdata` = colour replicated 4 times. Colour 0xA gives 0xAAAA.
- The engine writes offsets 0..ROWS*ROW_WORDS-1 (0..15999) of `cmd_page` in ascending order, one word per cycle.
- Then it goes to DONE.

Copy (op 2):
- For each destination row y, the source row is y - vscroll.
- If the source row is outside 0..ROWS-1, destination row y is skipped and no access is made for it.
- Row order:
  - vscroll > 0: rows are processed from y = ROWS-1 down to 0.
  - vscroll ≤ 0: rows are processed from 0 up to ROWS-1.
  - This makes a same-page scroll correct.
- Words within a row are processed in ascending order.
- Each word takes two states:
  - COPY_RD issues `mem_re` on the source address.
  - COPY_WR issues `mem_we` to the destination address, with `mem_wdata` = `mem_rdata`.
- Special cases:
  - If src==dst and vscroll==0, the engine goes straight to DONE with no accesses.
  - If |vscroll| ≥ ROWS, every row is skipped and the engine goes straight to DONE.

Reserved (op 3):
- The engine goes to DONE with no side effects.

General:
- Row and word counters never wrap. Address = `{page, row*ROW_WORDS + word}` computed at 14 bits, with no overflow since the maximum is 15999.
- `mem_we` and `mem_re` are never asserted together.
- `busy` = state is FILL, COPY_RD or COPY_WR.
- Reset asserted mid-operation aborts the operation on that edge:
  - All strobes drop and the engine returns to IDLE.
  - No `done` pulse is produced.
  - `draw_page` returns to 0.
  - Partially written memory is left as is.

## Timing
- Select: accepted at edge N. `draw_page` is updated and `done`=1 after edge N+1. `cmd_ready` is back to 1 after edge N+2.
- Fill: accepted at edge N. First write is visible after edge N+1. The last write is in cycle N+16000. `done` pulses in cycle N+16001. Total is 16002 cycles until ready again.
- Copy: each row that is copied costs 2*ROW_WORDS = 160 cycles. Skipped rows cost 0 cycles because the counter jumps straight to the next valid row. Fixed overhead is 1 cycle to enter the first state plus 1 DONE cycle.
- Full copy with vscroll=0 and src≠dst: 32000 access cycles. `done` pulses 32001 cycles after the accept edge.
- `done` is high for exactly one cycle, in DONE. DONE→IDLE is unconditional.
- A command presented while busy is held off by `cmd_ready`=0. The upstream CPU must keep `cmd_valid` and the fields stable until accepted.

## Test plan
- Reset then select: reset held 2 cycles, then select page 2 → `draw_page`=2 one edge after accept, one `done` pulse, zero memory strobes.
- Fill page 1 with colour 5 → 16000 writes to 0x4000..0x7E7F with data 0x5555, `done` at accept+16001, `busy` low afterwards.
- Copy page 0 to page 3 with vscroll=0, source preloaded with data = address → dst[0xC000+k] = k for all k < 16000, reads and writes strictly alternating.
- Same-page scroll on page 0, vscroll=+10, rows preloaded with data = row index → rows 10..199 hold values 0..189, rows 0..9 untouched, bottom-up order checked by bench scoreboard.
- Copy with vscroll=-199 → only dst row 0 is written, from src row 199, 160 access cycles. Copy with vscroll=200 → no accesses, immediate `done`.
- Reset asserted at cycle 500 of a fill → strobes low and state IDLE on the next edge, no `done`. A subsequent select is accepted normally.
